// File: rtl/pacman_controller.sv
`default_nettype none
// ============================================================================
// Module      : pacman_controller
// Description : Player movement stage. Decodes keyboard keycodes into a
//               requested direction and moves Pac-Man by one tile per move
//               tick. Wall data comes from an external synchronous wall-row
//               ROM through a read port owned by this block. A requested turn
//               stays buffered until the maze lets it be taken.
// Ports       : clk2          game clock
//               reset         asynchronous, active-high
//               move_tick     1-cycle pulse requesting one movement step
//               freeze        hold position / abort a step in progress
//               keycode       USB HID keycode, sampled every cycle
//               wall_row_addr row index presented to the wall ROM
//               wall_row_data ROM row for the previous cycle's address
//               pacman_x/y    current tile coordinates
//               pac_dir       0 none, 1 up, 2 down, 3 left, 4 right
//               moved         1-cycle pulse: position changed this step
// Revision    : 1.0 - initial release
// ============================================================================
module pacman_controller #(
    parameter int COLS    = 21,
    parameter int ROWS    = 31,
    parameter int START_X = 10,
    parameter int START_Y = 15,
    parameter int TUNNEL  = 1
) (
    input  logic            clk2,
    input  logic            reset,
    input  logic            move_tick,
    input  logic            freeze,
    input  logic [7:0]      keycode,
    output logic [4:0]      wall_row_addr,
    input  logic [COLS-1:0] wall_row_data,
    output logic [4:0]      pacman_x,
    output logic [4:0]      pacman_y,
    output logic [2:0]      pac_dir,
    output logic            moved
);

    localparam logic [4:0] c_last_col = 5'(COLS - 1);
    localparam logic [4:0] c_last_row = 5'(ROWS - 1);
    localparam logic [4:0] c_start_x  = 5'(START_X);
    localparam logic [4:0] c_start_y  = 5'(START_Y);
    localparam logic       c_tunnel   = (TUNNEL != 0);

    localparam logic [2:0] c_dir_none  = 3'd0;
    localparam logic [2:0] c_dir_up    = 3'd1;
    localparam logic [2:0] c_dir_down  = 3'd2;
    localparam logic [2:0] c_dir_left  = 3'd3;
    localparam logic [2:0] c_dir_right = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CUR  = 3'd1,
        S_UP   = 3'd2,
        S_DN   = 3'd3,
        S_DEC  = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [4:0]      r_x;
    logic [4:0]      r_y;
    logic [2:0]      r_pac_dir;
    logic [2:0]      r_want_dir;
    logic            r_moved;
    logic [COLS-1:0] r_cur_row;
    logic [COLS-1:0] r_up_row;

    logic [4:0]      w_x_dec;
    logic [4:0]      w_x_inc;
    logic [7:0]      w_open;
    logic            w_take_want;
    logic            w_take_cur;
    logic [2:0]      w_step_dir;
    logic [4:0]      w_next_x;
    logic [4:0]      w_next_y;

    assign pacman_x = r_x;
    assign pacman_y = r_y;
    assign pac_dir  = r_pac_dir;
    assign moved    = r_moved;

    assign w_x_dec = r_x - 5'd1;
    assign w_x_inc = r_x + 5'd1;

    // ------------------------------------------------------------------
    // Direction request register: unrecognised codes (including 0x00)
    // keep the previous request so a turn stays buffered.
    // ------------------------------------------------------------------
    always_ff @(posedge clk2 or posedge reset) begin
        if (reset) begin
            r_want_dir <= c_dir_none;
        end else begin
            case (keycode)
                8'h1A:   r_want_dir <= c_dir_up;
                8'h16:   r_want_dir <= c_dir_down;
                8'h04:   r_want_dir <= c_dir_left;
                8'h07:   r_want_dir <= c_dir_right;
                default: r_want_dir <= r_want_dir;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Passability per direction, indexed by direction code. Only
    // meaningful in S_DEC, where wall_row_data holds the row below.
    // Board top/bottom edges block regardless of the wrapped ROM read.
    // ------------------------------------------------------------------
    always_comb begin
        w_open              = 8'h00;
        w_open[c_dir_up]    = (r_y != 5'd0) && !r_up_row[r_x];
        w_open[c_dir_down]  = (r_y != c_last_row) && !wall_row_data[r_x];
        w_open[c_dir_left]  = (r_x != 5'd0) ? !r_cur_row[w_x_dec]
                                            : (c_tunnel && !r_cur_row[COLS-1]);
        w_open[c_dir_right] = (r_x != c_last_col) ? !r_cur_row[w_x_inc]
                                                  : (c_tunnel && !r_cur_row[0]);
    end

    // The requested turn has priority; otherwise keep going straight.
    assign w_take_want = (r_want_dir != c_dir_none) && w_open[r_want_dir];
    assign w_take_cur  = (r_pac_dir  != c_dir_none) && w_open[r_pac_dir];
    assign w_step_dir  = w_take_want ? r_want_dir : r_pac_dir;

    // Horizontal wrap is only reachable when the tunnel made it open.
    always_comb begin
        w_next_x = r_x;
        w_next_y = r_y;
        case (w_step_dir)
            c_dir_up:    w_next_y = r_y - 5'd1;
            c_dir_down:  w_next_y = r_y + 5'd1;
            c_dir_left:  w_next_x = (r_x == 5'd0) ? c_last_col : w_x_dec;
            c_dir_right: w_next_x = (r_x == c_last_col) ? 5'd0 : w_x_inc;
            default: begin
                w_next_x = r_x;
                w_next_y = r_y;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer: the ROM answers one cycle after the address, so rows
    // y, y-1 and y+1 arrive in S_UP, S_DN and S_DEC respectively.
    // ------------------------------------------------------------------
    always_ff @(posedge clk2 or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        wall_row_addr = r_y;
        case (r_state)
            S_IDLE: begin
                if (move_tick && !freeze) begin
                    w_state_next = S_CUR;
                end
            end
            S_CUR: begin
                w_state_next = freeze ? S_IDLE : S_UP;
            end
            S_UP: begin
                wall_row_addr = r_y - 5'd1;
                w_state_next  = freeze ? S_IDLE : S_DN;
            end
            S_DN: begin
                wall_row_addr = r_y + 5'd1;
                w_state_next  = freeze ? S_IDLE : S_DEC;
            end
            S_DEC: begin
                wall_row_addr = r_y + 5'd1;
                w_state_next  = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Row capture and position update.
    // ------------------------------------------------------------------
    always_ff @(posedge clk2 or posedge reset) begin
        if (reset) begin
            r_x       <= c_start_x;
            r_y       <= c_start_y;
            r_pac_dir <= c_dir_none;
            r_moved   <= 1'b0;
            r_cur_row <= '0;
            r_up_row  <= '0;
        end else begin
            r_moved <= 1'b0;
            case (r_state)
                S_UP: r_cur_row <= wall_row_data;
                S_DN: r_up_row  <= wall_row_data;
                S_DEC: begin
                    if (!freeze && (w_take_want || w_take_cur)) begin
                        r_x       <= w_next_x;
                        r_y       <= w_next_y;
                        r_pac_dir <= w_step_dir;
                        r_moved   <= 1'b1;
                    end
                end
                default: begin
                    r_moved <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pacman_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pacman_controller
// Description : Directed self-checking bench for pacman_controller. Two
//               instances share stimulus and maze contents: one with the
//               tunnel enabled, one with it disabled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pacman_controller;

    logic        clk2 = 1'b0;
    logic        reset;
    logic        move_tick;
    logic        freeze;
    logic [7:0]  keycode;

    logic [4:0]  addr_a, addr_b;
    logic [20:0] data_a, data_b;
    logic [4:0]  x_a, y_a, x_b, y_b;
    logic [2:0]  dir_a, dir_b;
    logic        moved_a, moved_b;

    logic [20:0] rom [0:31];

    int          checks = 0;
    int          errors = 0;
    logic [4:0]  a_addr [0:3];
    logic [4:0]  e_x, e_y;
    logic        e_moved;
    int          pulses;

    always #5 clk2 = ~clk2;

    // Synchronous wall ROM models, one read port per instance.
    always @(posedge clk2) data_a <= rom[addr_a];
    always @(posedge clk2) data_b <= rom[addr_b];

    pacman_controller #(.COLS(21), .ROWS(31), .START_X(10), .START_Y(15), .TUNNEL(1)) dut_a (
        .clk2(clk2), .reset(reset), .move_tick(move_tick), .freeze(freeze),
        .keycode(keycode), .wall_row_addr(addr_a), .wall_row_data(data_a),
        .pacman_x(x_a), .pacman_y(y_a), .pac_dir(dir_a), .moved(moved_a)
    );

    pacman_controller #(.COLS(21), .ROWS(31), .START_X(10), .START_Y(15), .TUNNEL(0)) dut_b (
        .clk2(clk2), .reset(reset), .move_tick(move_tick), .freeze(freeze),
        .keycode(keycode), .wall_row_addr(addr_b), .wall_row_data(data_b),
        .pacman_x(x_b), .pacman_y(y_b), .pac_dir(dir_b), .moved(moved_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [7:0] k);
        @(negedge clk2) keycode = k;
        @(negedge clk2) keycode = 8'h00;
    endtask

    // One tick; returns at the negedge after the update edge (N+4).
    task automatic do_tick();
        @(negedge clk2) move_tick = 1'b1;
        @(negedge clk2) move_tick = 1'b0; a_addr[0] = addr_a;
        @(negedge clk2) a_addr[1] = addr_a;
        @(negedge clk2) a_addr[2] = addr_a;
        @(negedge clk2) a_addr[3] = addr_a;
        e_x = x_a; e_y = y_a; e_moved = moved_a;
        @(negedge clk2);
    endtask

    task automatic pulse_reset();
        @(negedge clk2) reset = 1'b1;
        @(negedge clk2) reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 21'h0;
        reset = 1'b1; move_tick = 1'b0; freeze = 1'b0; keycode = 8'h00;
        repeat (2) @(negedge clk2);

        // Reset state
        chk("rst_x", 32'(x_a), 10);
        chk("rst_y", 32'(y_a), 15);
        chk("rst_dir", 32'(dir_a), 0);
        chk("rst_moved", 32'(moved_a), 0);
        chk("rst_addr", 32'(addr_a), 15);
        chk("rst_x_b", 32'(x_b), 10);
        @(negedge clk2) reset = 1'b0;

        // Tick with no direction at all: nothing moves; ROM address sequence
        do_tick();
        chk("nodir_x", 32'(x_a), 10);
        chk("nodir_moved", 32'(moved_a), 0);
        chk("addr_cur", 32'(a_addr[0]), 15);
        chk("addr_up", 32'(a_addr[1]), 14);
        chk("addr_dn", 32'(a_addr[2]), 16);
        chk("addr_dec", 32'(a_addr[3]), 16);

        // Press D, one tick: update lands on edge N+4 and moved pulses once
        press(8'h07);
        do_tick();
        chk("lat_x_before", 32'(e_x), 10);
        chk("lat_moved_before", 32'(e_moved), 0);
        chk("right_x", 32'(x_a), 11);
        chk("right_y", 32'(y_a), 15);
        chk("right_dir", 32'(dir_a), 4);
        chk("right_moved", 32'(moved_a), 1);
        @(negedge clk2);
        chk("right_moved_drop", 32'(moved_a), 0);

        // Buffered turn: up walled at x=11,12, open at 13
        rom[14] = (21'h1 << 11) | (21'h1 << 12);
        press(8'h1A);
        do_tick();
        chk("buf1_x", 32'(x_a), 12);
        chk("buf1_dir", 32'(dir_a), 4);
        do_tick();
        chk("buf2_x", 32'(x_a), 13);
        chk("buf2_y", 32'(y_a), 15);
        do_tick();
        chk("buf3_x", 32'(x_a), 13);
        chk("buf3_y", 32'(y_a), 14);
        chk("buf3_dir", 32'(dir_a), 1);
        rom[14] = 21'h0;

        // Dead end at (5,15) heading left
        pulse_reset();
        press(8'h04);
        repeat (5) do_tick();
        chk("dead_pre_x", 32'(x_a), 5);
        chk("dead_pre_dir", 32'(dir_a), 3);
        rom[15][4] = 1'b1;
        do_tick();
        chk("dead_x", 32'(x_a), 5);
        chk("dead_y", 32'(y_a), 15);
        chk("dead_moved", 32'(moved_a), 0);
        chk("dead_dir", 32'(dir_a), 3);
        rom[15] = 21'h0;

        // Reset in the middle of a step
        @(negedge clk2) move_tick = 1'b1;
        @(negedge clk2) move_tick = 1'b0;
        @(negedge clk2) reset = 1'b1;
        #1;
        chk("midrst_x", 32'(x_a), 10);
        chk("midrst_dir", 32'(dir_a), 0);
        chk("midrst_addr", 32'(addr_a), 15);
        @(negedge clk2) reset = 1'b0;
        do_tick();
        chk("midrst_nowant_x", 32'(x_a), 10);
        chk("midrst_nowant_moved", 32'(moved_a), 0);

        // Top row edge: wrapped ROM read of row 31 is open but must not count
        press(8'h1A);
        repeat (15) do_tick();
        chk("top_reach_y", 32'(y_a), 0);
        do_tick();
        chk("top_addr_wrap", 32'(a_addr[1]), 31);
        chk("top_y", 32'(y_a), 0);
        chk("top_moved", 32'(moved_a), 0);

        // Tunnel: walk to (0,9), then left once more
        pulse_reset();
        press(8'h1A);
        repeat (6) do_tick();
        press(8'h04);
        repeat (10) do_tick();
        chk("tun_pre_x", 32'(x_a), 0);
        chk("tun_pre_y", 32'(y_a), 9);
        chk("tun_pre_x_b", 32'(x_b), 0);
        do_tick();
        chk("tun_x", 32'(x_a), 20);
        chk("tun_y", 32'(y_a), 9);
        chk("tun_moved", 32'(moved_a), 1);
        chk("notun_x_b", 32'(x_b), 0);
        chk("notun_moved_b", 32'(moved_b), 0);
        chk("notun_dir_b", 32'(dir_b), 3);
        press(8'h07);
        do_tick();
        chk("tun_back_x", 32'(x_a), 0);
        chk("notun_right_x_b", 32'(x_b), 1);

        // Freeze during S_UP aborts the step
        pulse_reset();
        press(8'h07);
        @(negedge clk2) move_tick = 1'b1;
        @(negedge clk2) move_tick = 1'b0;
        @(negedge clk2) freeze = 1'b1;
        @(negedge clk2) freeze = 1'b0;
        chk("abort_idle_addr", 32'(addr_a), 15);
        pulses = 0;
        repeat (6) begin
            @(negedge clk2);
            if (moved_a) pulses++;
        end
        chk("abort_pulses", 32'(pulses), 0);
        chk("abort_x", 32'(x_a), 10);

        // Tick while frozen in idle is ignored
        @(negedge clk2) begin freeze = 1'b1; move_tick = 1'b1; end
        @(negedge clk2) begin freeze = 1'b0; move_tick = 1'b0; end
        repeat (6) @(negedge clk2);
        chk("frz_idle_x", 32'(x_a), 10);

        // Second tick at N+2 is dropped: exactly one step
        @(negedge clk2) move_tick = 1'b1;
        @(negedge clk2) move_tick = 1'b0;
        @(negedge clk2) move_tick = 1'b1;
        @(negedge clk2) move_tick = 1'b0;
        @(negedge clk2);
        @(negedge clk2);
        chk("drop_x", 32'(x_a), 11);
        chk("drop_moved", 32'(moved_a), 1);
        pulses = 0;
        repeat (12) begin
            @(negedge clk2);
            if (moved_a) pulses++;
        end
        chk("drop_extra_pulses", 32'(pulses), 0);
        chk("drop_x_final", 32'(x_a), 11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
